// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter: start, 8 data bits LSB first, optional parity, 1 or 2 stop bits
module uart_tx #(
    parameter int UART_CLK_CNT = 434,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       uart_tx_pin,
    output logic       tx_busy,
    output logic       tx_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    localparam logic [16:0] CNT_MAX   = 17'(UART_CLK_CNT - 1);
    localparam logic [2:0]  STOP_LAST = 3'(STOP_BITS - 1);
    localparam logic        ODD       = 1'(PARITY_ODD);

    state_t      state;
    logic [16:0] clk_cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  shreg;
    logic        par_bit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            clk_cnt     <= '0;
            bit_cnt     <= '0;
            shreg       <= '0;
            par_bit     <= 1'b0;
            uart_tx_pin <= 1'b1;
            tx_ready    <= 1'b0;
            tx_busy     <= 1'b0;
            tx_done     <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            if (state == S_IDLE) begin
                clk_cnt <= '0;
                bit_cnt <= '0;
                if (tx_ready && tx_valid) begin
                    // Parity is taken from the byte as latched, so later tx_data changes cannot affect it.
                    shreg       <= tx_data;
                    par_bit     <= (^tx_data) ^ ODD;
                    uart_tx_pin <= 1'b0;
                    tx_ready    <= 1'b0;
                    tx_busy     <= 1'b1;
                    state       <= S_START;
                end else begin
                    tx_ready <= 1'b1;
                end
            end else if (clk_cnt != CNT_MAX) begin
                clk_cnt <= clk_cnt + 17'd1;
            end else begin
                clk_cnt <= '0;
                case (state)
                    S_START: begin
                        uart_tx_pin <= shreg[0];
                        shreg       <= {1'b0, shreg[7:1]};
                        bit_cnt     <= '0;
                        state       <= S_DATA;
                    end
                    S_DATA: begin
                        if (bit_cnt == 3'd7) begin
                            bit_cnt <= '0;
                            if (PARITY_EN != 0) begin
                                uart_tx_pin <= par_bit;
                                state       <= S_PARITY;
                            end else begin
                                uart_tx_pin <= 1'b1;
                                state       <= S_STOP;
                            end
                        end else begin
                            uart_tx_pin <= shreg[0];
                            shreg       <= {1'b0, shreg[7:1]};
                            bit_cnt     <= bit_cnt + 3'd1;
                        end
                    end
                    S_PARITY: begin
                        uart_tx_pin <= 1'b1;
                        bit_cnt     <= '0;
                        state       <= S_STOP;
                    end
                    S_STOP: begin
                        // bit_cnt counts completed stop bits; the last one returns to IDLE.
                        if (bit_cnt == STOP_LAST) begin
                            state    <= S_IDLE;
                            tx_ready <= 1'b1;
                            tx_busy  <= 1'b0;
                            tx_done  <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - directed bench for uart_tx in 8N1, even/odd parity and 2-stop-bit builds
module tb_uart_tx;

    localparam int N = 4;

    logic       clk;
    logic       rst;
    logic [3:0] tx_valid_v;
    logic [7:0] tx_data_v [4];
    wire  [3:0] pin_v;
    wire  [3:0] rdy_v;
    wire  [3:0] busy_v;
    wire  [3:0] done_v;

    int checks = 0;
    int errors = 0;

    logic cap_pin  [200];
    logic cap_rdy  [200];
    logic cap_busy [200];
    logic cap_done [200];

    // dut 0: 8N1, dut 1: even parity, dut 2: odd parity, dut 3: two stop bits
    uart_tx #(.UART_CLK_CNT(N)) u_8n1 (
        .clk(clk), .rst(rst), .tx_data(tx_data_v[0]), .tx_valid(tx_valid_v[0]),
        .tx_ready(rdy_v[0]), .uart_tx_pin(pin_v[0]), .tx_busy(busy_v[0]), .tx_done(done_v[0]));
    uart_tx #(.UART_CLK_CNT(N), .PARITY_EN(1), .PARITY_ODD(0)) u_even (
        .clk(clk), .rst(rst), .tx_data(tx_data_v[1]), .tx_valid(tx_valid_v[1]),
        .tx_ready(rdy_v[1]), .uart_tx_pin(pin_v[1]), .tx_busy(busy_v[1]), .tx_done(done_v[1]));
    uart_tx #(.UART_CLK_CNT(N), .PARITY_EN(1), .PARITY_ODD(1)) u_odd (
        .clk(clk), .rst(rst), .tx_data(tx_data_v[2]), .tx_valid(tx_valid_v[2]),
        .tx_ready(rdy_v[2]), .uart_tx_pin(pin_v[2]), .tx_busy(busy_v[2]), .tx_done(done_v[2]));
    uart_tx #(.UART_CLK_CNT(N), .STOP_BITS(2)) u_stop2 (
        .clk(clk), .rst(rst), .tx_data(tx_data_v[3]), .tx_valid(tx_valid_v[3]),
        .tx_ready(rdy_v[3]), .uart_tx_pin(pin_v[3]), .tx_busy(busy_v[3]), .tx_done(done_v[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Offers byte b to dut d, then records outputs at the falling edge after edges T0..T0+ncyc-1.
    // mode 0: single byte; 1: valid held, data switched to b2; 2: valid/data toggled mid-frame; 3: rst pulse at T0+13
    task automatic capture(input int d, input logic [7:0] b, input logic [7:0] b2, input int ncyc, input int mode);
        int w;
        w = 0;
        @(negedge clk);
        tx_valid_v[d] = 1'b1;
        tx_data_v[d]  = b;
        while (rdy_v[d] !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (w >= 20) begin
            errors++;
            $display("FAIL accept_timeout dut%0d: tx_ready=%b, required 1", d, rdy_v[d]);
            tx_valid_v[d] = 1'b0;
        end else begin
            @(negedge clk);
            for (int c = 0; c < ncyc; c++) begin
                if (c > 0) @(negedge clk);
                cap_pin[c]  = pin_v[d];
                cap_rdy[c]  = rdy_v[d];
                cap_busy[c] = busy_v[d];
                cap_done[c] = done_v[d];
                case (mode)
                    1: begin
                        if (c == 0) tx_data_v[d] = b2;
                        if (c == 41) tx_valid_v[d] = 1'b0;
                    end
                    2: begin
                        tx_data_v[d]  = ~tx_data_v[d];
                        tx_valid_v[d] = (c < 36) && (c % 3 == 0);
                    end
                    3: begin
                        tx_valid_v[d] = 1'b0;
                        if (c == 12) rst = 1'b1;
                        if (c == 13) rst = 1'b0;
                    end
                    default: tx_valid_v[d] = 1'b0;
                endcase
            end
            tx_valid_v[d] = 1'b0;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tx_valid_v = '0;
        for (int i = 0; i < 4; i++) tx_data_v[i] = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({pin_v[i], rdy_v[i], busy_v[i], done_v[i]} !== 4'b1000) begin
                errors++;
                $display("FAIL reset_outputs dut%0d: pin/ready/busy/done=%b%b%b%b, required 1000",
                         i, pin_v[i], rdy_v[i], busy_v[i], done_v[i]);
            end
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (rdy_v[0] !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset: tx_ready=%b, required 1", rdy_v[0]);
        end
    endtask

    task automatic test_8n1;
        logic [9:0] f;
        f = 10'b1_10100101_0;
        capture(0, 8'hA5, 8'h00, 46, 0);
        for (int c = 0; c < 46; c++) begin
            checks++;
            if (cap_pin[c] !== ((c < 40) ? f[c / N] : 1'b1)) begin
                errors++;
                $display("FAIL 8n1_pin cycle %0d: pin=%b, required %b", c, cap_pin[c], (c < 40) ? f[c / N] : 1'b1);
            end
            checks++;
            if (cap_done[c] !== (c == 40) || cap_rdy[c] !== (c >= 40) || cap_busy[c] !== (c < 40)) begin
                errors++;
                $display("FAIL 8n1_flags cycle %0d: done/ready/busy=%b%b%b, required %b%b%b",
                         c, cap_done[c], cap_rdy[c], cap_busy[c], c == 40, c >= 40, c < 40);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [9:0] f1;
        logic [9:0] f2;
        logic [7:0] rx;
        f1 = 10'b1_00000000_0;
        f2 = 10'b1_11111111_0;
        capture(0, 8'h00, 8'hFF, 86, 1);
        for (int c = 0; c < 86; c++) begin
            checks++;
            if (cap_pin[c] !== ((c < 40) ? f1[c / N] : (c == 40) ? 1'b1 : (c < 81) ? f2[(c - 41) / N] : 1'b1)) begin
                errors++;
                $display("FAIL b2b_pin cycle %0d: pin=%b", c, cap_pin[c]);
            end
            checks++;
            if (cap_done[c] !== (c == 40 || c == 81)) begin
                errors++;
                $display("FAIL b2b_done cycle %0d: done=%b, required %b", c, cap_done[c], c == 40 || c == 81);
            end
        end
        checks++;
        if (cap_rdy[40] !== 1'b1 || cap_rdy[41] !== 1'b0 || cap_busy[41] !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accept: ready40=%b ready41=%b busy41=%b, required 1 0 1", cap_rdy[40], cap_rdy[41], cap_busy[41]);
        end
        for (int fr = 0; fr < 2; fr++) begin
            for (int i = 0; i < 8; i++) rx[i] = cap_pin[fr * 41 + (i + 1) * N + N / 2];
            checks++;
            if (rx !== ((fr == 0) ? 8'h00 : 8'hFF)) begin
                errors++;
                $display("FAIL b2b_recovered frame %0d: got %h, required %h", fr, rx, (fr == 0) ? 8'h00 : 8'hFF);
            end
        end
    endtask

    task automatic test_parity;
        logic [10:0] f;
        for (int d = 1; d <= 2; d++) begin
            f = (d == 1) ? 11'b1_1_00000111_0 : 11'b1_0_00000111_0;
            capture(d, 8'h07, 8'h00, 48, 0);
            for (int c = 0; c < 48; c++) begin
                checks++;
                if (cap_pin[c] !== ((c < 44) ? f[c / N] : 1'b1)) begin
                    errors++;
                    $display("FAIL parity_pin dut%0d cycle %0d: pin=%b, required %b", d, c, cap_pin[c], (c < 44) ? f[c / N] : 1'b1);
                end
                checks++;
                if (cap_done[c] !== (c == 44) || cap_rdy[c] !== (c >= 44)) begin
                    errors++;
                    $display("FAIL parity_flags dut%0d cycle %0d: done/ready=%b%b, required %b%b", d, c, cap_done[c], cap_rdy[c], c == 44, c >= 44);
                end
            end
        end
    endtask

    task automatic test_stop2;
        logic [10:0] f;
        f = 11'b11_00111100_0;
        capture(3, 8'h3C, 8'h00, 48, 0);
        for (int c = 0; c < 48; c++) begin
            checks++;
            if (cap_pin[c] !== ((c < 44) ? f[c / N] : 1'b1)) begin
                errors++;
                $display("FAIL stop2_pin cycle %0d: pin=%b, required %b", c, cap_pin[c], (c < 44) ? f[c / N] : 1'b1);
            end
            checks++;
            if (cap_done[c] !== (c == 44) || cap_busy[c] !== (c < 44)) begin
                errors++;
                $display("FAIL stop2_flags cycle %0d: done/busy=%b%b, required %b%b", c, cap_done[c], cap_busy[c], c == 44, c < 44);
            end
        end
    endtask

    task automatic test_midframe_changes;
        logic [9:0] f;
        f = 10'b1_10010110_0;
        capture(0, 8'h96, 8'h00, 60, 2);
        for (int c = 0; c < 60; c++) begin
            checks++;
            if (cap_pin[c] !== ((c < 40) ? f[c / N] : 1'b1)) begin
                errors++;
                $display("FAIL midframe_pin cycle %0d: pin=%b, required %b", c, cap_pin[c], (c < 40) ? f[c / N] : 1'b1);
            end
            checks++;
            if (cap_done[c] !== (c == 40) || cap_busy[c] !== (c < 40)) begin
                errors++;
                $display("FAIL midframe_flags cycle %0d: done/busy=%b%b, required %b%b", c, cap_done[c], cap_busy[c], c == 40, c < 40);
            end
        end
    endtask

    task automatic test_reset_midframe;
        logic [9:0] f;
        f = 10'b1_11000011_0;
        capture(0, 8'hC3, 8'h00, 60, 3);
        for (int c = 0; c < 60; c++) begin
            checks++;
            if (cap_pin[c] !== ((c < 13) ? f[c / N] : 1'b1) || cap_done[c] !== 1'b0) begin
                errors++;
                $display("FAIL rstmid_pin cycle %0d: pin/done=%b%b, required %b0", c, cap_pin[c], cap_done[c], (c < 13) ? f[c / N] : 1'b1);
            end
        end
        checks++;
        if ({cap_busy[13], cap_rdy[13], cap_rdy[14], cap_busy[14]} !== 4'b0010) begin
            errors++;
            $display("FAIL rstmid_flags: busy13 ready13 ready14 busy14=%b%b%b%b, required 0010",
                     cap_busy[13], cap_rdy[13], cap_rdy[14], cap_busy[14]);
        end
        f = 10'b1_01011010_0;
        capture(0, 8'h5A, 8'h00, 44, 0);
        for (int c = 0; c < 44; c++) begin
            checks++;
            if (cap_pin[c] !== ((c < 40) ? f[c / N] : 1'b1) || cap_done[c] !== (c == 40)) begin
                errors++;
                $display("FAIL rstmid_resend cycle %0d: pin/done=%b%b, required %b%b",
                         c, cap_pin[c], cap_done[c], (c < 40) ? f[c / N] : 1'b1, c == 40);
            end
        end
    endtask

    initial begin
        test_reset;
        test_8n1;
        test_back_to_back;
        test_parity;
        test_stop2;
        test_midframe_changes;
        test_reset_midframe;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter: the transmit-side counterpart of the UART receiver. It accepts one byte at a time over a valid/ready handshake and drives the idle-high serial line with a start bit, 8 data bits LSB first, an optional parity bit, and 1 or 2 stop bits. Every bit lasts exactly `UART_CLK_CNT` clock cycles. In loopback its output pin drives the receiver's `uart_rx_pin`.

## Interface
Parameters:
- `UART_CLK_CNT`, default 434: clock cycles per bit (50 MHz / 115200). Legal range 2..131071.
- `PARITY_EN`, default 0: 1 inserts a parity bit after the data bits.
- `PARITY_ODD`, default 0: 0 selects even parity, 1 selects odd. Ignored when `PARITY_EN`=0.
- `STOP_BITS`, default 1: number of stop bits, 1 or 2.

Ports:
- `clk` in 1: the single clock. All logic is on its rising edge.
- `rst` in 1: reset is synchronous and active-high.
- `tx_data` in 8: byte to send. Sampled only on the accept edge.
- `tx_valid` in 1: upstream has a byte on `tx_data`.
- `tx_ready` out 1: block can accept a byte (high only in IDLE).
- `uart_tx_pin` out 1: serial line, idle high.
- `tx_busy` out 1: a frame is in progress.
- `tx_done` out 1: one-cycle pulse when a frame's last stop bit completes.

## Operation
- All outputs are registered.
- Reset values: `uart_tx_pin`=1, `tx_ready`=0, `tx_busy`=0, `tx_done`=0. State resets to IDLE, with bit counter and cycle counter at 0.
- `tx_ready` rises on the first edge after `rst` deasserts.
- States:
  - IDLE → START on accept (`tx_valid` & `tx_ready` at an edge).
  - START → DATA after N cycles.
  - DATA → PARITY after 8 bits if `PARITY_EN`, else DATA → STOP.
  - PARITY → STOP after N cycles.
  - STOP → IDLE after `STOP_BITS`×N cycles.
- On the accept edge:
  - latch `tx_data` into a shift register;
  - `uart_tx_pin`<=0, `tx_ready`<=0, `tx_busy`<=1;
  - clear the cycle counter.
- The cycle counter counts 0..N-1 within each bit, where N = `UART_CLK_CNT`. At count N-1 it wraps to 0 and the next bit value is registered onto `uart_tx_pin`.
- DATA: data bit i (LSB first) is driven for N cycles, for i = 0..7.
- Parity bit = XOR of the latched byte, inverted when `PARITY_ODD`=1.
- STOP: pin held at 1. With `STOP_BITS`=2 the stop phase lasts 2N cycles.
- On the final edge of STOP, in a single edge:
  - state → IDLE;
  - `tx_ready`<=1, `tx_busy`<=0;
  - `tx_done`<=1 for exactly one cycle;
  - pin stays 1.
- `tx_valid` and `tx_data` are ignored while `tx_ready`=0. Changing `tx_data` mid-frame has no effect on the frame.
- `rst` asserted mid-frame: at the next edge all outputs take their reset values and the frame is abandoned, with no `tx_done`. The pin returns high immediately, which may truncate a bit.
- Counter width: 17 bits, matching the receiver's `clk_cnt`.

## Timing
- Let T0 be the accept edge and F = 1 + 8 + `PARITY_EN` + `STOP_BITS`.
- Pin is low in cycles [T0, T0+N), where cycle k means after edge k.
- Data bit i occupies [T0+(1+i)N, T0+(2+i)N).
- Parity bit, if enabled, occupies [T0+9N, T0+10N).
- Stop bits occupy from the end of the last data/parity bit until T0+F·N.
- Edge T0+F·N: `tx_done`=1, `tx_ready`=1, `tx_busy`=0. `tx_done` clears at edge T0+F·N+1.
- Back-to-back: if `tx_valid` is held high, the next accept occurs at edge T0+F·N+1, and its start bit begins there. Minimum accept-to-accept interval is F·N+1 cycles, so the line idles one cycle beyond the stop bits.
- Latency from accept to start-bit falling edge: 0 cycles (registered at the accept edge).

## Test plan
- N=4, 8N1, send 0xA5 with `tx_valid` high for one cycle. Pin sampled mid-bit reads 0, 1,0,1,0,0,1,0,1, 1. `tx_done` pulses at T0+40. `tx_ready` is low for exactly 40 cycles.
- N=4, `tx_valid` held high with 0x00 then 0xFF. Second accept at T0+41. The second frame's start bit follows exactly one extra idle cycle. Both bytes are recovered by the `UART_Rx` loopback.
- `PARITY_EN`=1, `PARITY_ODD`=0, send 0x07: parity bit = 1, frame = 11N. Repeat with `PARITY_ODD`=1: parity bit = 0.
- `STOP_BITS`=2, N=4, send 0x3C: pin high for 8 cycles after bit 7. `tx_done` pulses at T0+44.
- `tx_data` changed and `tx_valid` toggled mid-frame: the transmitted byte equals the latched value and no extra frame starts.
- `rst` pulsed at T0+13 (mid data bit): next edge pin=1, `tx_busy`=0, `tx_ready`=0, no `tx_done` ever. `tx_ready`=1 one edge after `rst` deasserts, and the next byte then transmits cleanly.
